// File: rtl/uart_mem_cmd_ctrl_if.sv
// Signal bundle between the UART command controller and its receiver, memory and transmitter.
// master = controller side, slave = environment side.
interface uart_mem_cmd_ctrl_if #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 32
);
  logic                 rx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic [ADDR_BITS-1:0] rx_addr;
  logic                 rx_mem_type;
  logic                 rx_rw_flag;
  logic                 imem_we;
  logic                 dmem_we;
  logic                 mem_re;
  logic                 mem_sel;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 cpu_hold;
  logic                 busy;
  logic [7:0]           drop_cnt;

  modport master (
    input  rx_done, rx_data, rx_addr, rx_mem_type, rx_rw_flag, mem_rdata, tx_busy, tx_done,
    output imem_we, dmem_we, mem_re, mem_sel, mem_addr, mem_wdata, tx_start, tx_data,
           cpu_hold, busy, drop_cnt
  );

  modport slave (
    output rx_done, rx_data, rx_addr, rx_mem_type, rx_rw_flag, mem_rdata, tx_busy, tx_done,
    input  imem_we, dmem_we, mem_re, mem_sel, mem_addr, mem_wdata, tx_start, tx_data,
           cpu_hold, busy, drop_cnt
  );
endinterface

// File: rtl/uart_mem_cmd_ctrl.sv
// Turns decoded UART command packets into instruction/data memory writes and MSB-first read-backs.
// Optional feature macro: UART_WRITE_ACK_EN (send an 8'hA5 acknowledge byte after each write).
module uart_mem_cmd_ctrl #(
  parameter int ADDR_BITS  = 9,
  parameter int BYTE_COUNT = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  uart_mem_cmd_ctrl_if.master bus
);
  localparam int DATA_BITS = 8 * BYTE_COUNT;
  localparam int IDX_BITS  = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_REQ   = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_TX_BYTE  = 3'd4,
    ST_TX_WAIT  = 3'd5
`ifdef UART_WRITE_ACK_EN
    ,
    ST_ACK      = 3'd6,
    ST_ACK_WAIT = 3'd7
`endif
  } state_t;

  state_t               state_r;
  logic                 imem_we_r;
  logic                 dmem_we_r;
  logic                 mem_re_r;
  logic                 mem_sel_r;
  logic [ADDR_BITS-1:0] mem_addr_r;
  logic [DATA_BITS-1:0] mem_wdata_r;
  logic [DATA_BITS-1:0] word_r;
  logic [IDX_BITS-1:0]  byte_idx_r;
  logic [1:0]           lat_cnt_r;
  logic                 tx_start_r;
  logic [7:0]           tx_data_r;
  logic [7:0]           drop_cnt_r;
  logic                 busy_s;

  assign busy_s       = (state_r != ST_IDLE);
  assign bus.busy     = busy_s;
  assign bus.cpu_hold = busy_s;
  assign bus.imem_we  = imem_we_r;
  assign bus.dmem_we  = dmem_we_r;
  assign bus.mem_re   = mem_re_r;
  assign bus.mem_sel  = mem_sel_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.drop_cnt = drop_cnt_r;

  // Command sequencer: strobes are registered so they are high exactly in the WRITE / RD_REQ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      imem_we_r   <= 1'b0;
      dmem_we_r   <= 1'b0;
      mem_re_r    <= 1'b0;
      mem_sel_r   <= 1'b0;
      mem_addr_r  <= {ADDR_BITS{1'b0}};
      mem_wdata_r <= {DATA_BITS{1'b0}};
      word_r      <= {DATA_BITS{1'b0}};
      byte_idx_r  <= {IDX_BITS{1'b0}};
      lat_cnt_r   <= 2'd0;
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      drop_cnt_r  <= 8'h00;
    end else begin
      imem_we_r  <= 1'b0;
      dmem_we_r  <= 1'b0;
      mem_re_r   <= 1'b0;
      tx_start_r <= 1'b0;
      if (bus.rx_done && busy_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.rx_done) begin
            mem_addr_r  <= bus.rx_addr;
            mem_sel_r   <= bus.rx_mem_type;
            mem_wdata_r <= bus.rx_data;
            if (bus.rx_rw_flag) begin
              imem_we_r <= ~bus.rx_mem_type;
              dmem_we_r <= bus.rx_mem_type;
              state_r   <= ST_WRITE;
            end else begin
              mem_re_r  <= 1'b1;
              state_r   <= ST_RD_REQ;
            end
          end
        end
        ST_WRITE: begin
`ifdef UART_WRITE_ACK_EN
          state_r <= ST_ACK;
`else
          state_r <= ST_IDLE;
`endif
        end
        ST_RD_REQ: begin
          lat_cnt_r <= 2'd0;
          state_r   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (lat_cnt_r == 2'(RD_LATENCY - 1)) begin
            word_r     <= bus.mem_rdata;
            byte_idx_r <= {IDX_BITS{1'b0}};
            state_r    <= ST_TX_BYTE;
          end else begin
            lat_cnt_r  <= lat_cnt_r + 2'd1;
          end
        end
        // The word is shifted left after each byte so the top byte is always the next one out.
        ST_TX_BYTE: begin
          if (!bus.tx_busy) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= word_r[DATA_BITS-1 -: 8];
            state_r    <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          if (bus.tx_done) begin
            if (byte_idx_r == IDX_BITS'(BYTE_COUNT - 1)) begin
              byte_idx_r <= {IDX_BITS{1'b0}};
              state_r    <= ST_IDLE;
            end else begin
              byte_idx_r <= byte_idx_r + IDX_BITS'(1);
              word_r     <= {word_r[DATA_BITS-9:0], 8'h00};
              state_r    <= ST_TX_BYTE;
            end
          end
        end
`ifdef UART_WRITE_ACK_EN
        ST_ACK: begin
          if (!bus.tx_busy) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= 8'hA5;
            state_r    <= ST_ACK_WAIT;
          end
        end
        ST_ACK_WAIT: begin
          if (bus.tx_done) begin
            state_r <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
// Scoreboard bench for uart_mem_cmd_ctrl: stimulus pushes expected strobes/bytes, a negedge monitor pops them.
module tb_uart_mem_cmd_ctrl;
  localparam logic [1:0] K_IMEM = 2'd0;
  localparam logic [1:0] K_DMEM = 2'd1;
  localparam logic [1:0] K_RE   = 2'd2;
  localparam logic [1:0] K_TX   = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [8:0]  addr;
    logic        sel;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   tx_seen = 0;
  int   tx_cnt = 0;
  int   bp_len = 0;
  int   bp_left = 0;
  int   rd_stage = 0;
  logic [31:0] rd_value = 32'h0;
  logic tx_done_m = 1'b0;
  logic tx_done_s = 1'b0;
  logic [3:0] mon_cur = 4'h0;
  logic [3:0] mon_prev = 4'h0;
  exp_t exp_q[$];
  exp_t mon_act;
  exp_t mon_exp;

  uart_mem_cmd_ctrl_if bus ();

  uart_mem_cmd_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.tx_done = tx_done_m | tx_done_s;

  function automatic exp_t mk(input logic [1:0] k, input logic [8:0] a, input logic s, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.sel  = s;
    e.data = d;
    return e;
  endfunction

  task automatic push_read(input logic [8:0] a, input logic s, input logic [31:0] w, input int nbytes);
    logic [31:0] v;
    v = w;
    exp_q.push_back(mk(K_RE, a, s, 32'h0));
    for (int i = 0; i < nbytes; i++) begin
      exp_q.push_back(mk(K_TX, 9'h0, 1'b0, {24'h0, v[31:24]}));
      v = {v[23:0], 8'h00};
    end
  endtask

  task automatic push_write(input logic [8:0] a, input logic s, input logic [31:0] d);
    exp_q.push_back(mk(s ? K_DMEM : K_IMEM, a, s, d));
`ifdef UART_WRITE_ACK_EN
    exp_q.push_back(mk(K_TX, 9'h0, 1'b0, 32'h0000_00A5));
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic rw, input logic typ, input logic [8:0] a, input logic [31:0] d);
    bus.rx_rw_flag  = rw;
    bus.rx_mem_type = typ;
    bus.rx_addr     = a;
    bus.rx_data     = d;
    bus.rx_done     = 1'b1;
    @(negedge clk);
    bus.rx_done     = 1'b0;
  endtask

  task automatic drop_pulse();
    send_cmd(1'b1, 1'b1, 9'h1FF, 32'hFFFF_0000);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.busy == 1'b0) break;
    end
    n_tests++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got %0d pending events busy=%b expected 0 pending busy=0", name, exp_q.size(), bus.busy);
    end
  endtask

  // Memory model: garbage on the mem_re cycle, the word one cycle later, garbage again after that.
  always @(negedge clk) begin
    if (reset) begin
      rd_stage      = 0;
      bus.mem_rdata = 32'hBAD0_BAD0;
    end else if (bus.mem_re) begin
      rd_stage      = 1;
      bus.mem_rdata = 32'hBAD0_BAD0;
    end else if (rd_stage == 1) begin
      rd_stage      = 2;
      bus.mem_rdata = rd_value;
    end else if (rd_stage == 2) begin
      rd_stage      = 0;
      bus.mem_rdata = 32'hBAD0_BAD0;
    end
  end

  // Transmitter model: 3 busy cycles per byte, then tx_done; optional extra busy window (backpressure).
  always @(negedge clk) begin
    tx_done_m = 1'b0;
    if (reset) begin
      tx_cnt      = 0;
      bp_left     = 0;
      bus.tx_busy = 1'b0;
    end else if (bus.tx_start) begin
      n_tests++;
      if (bus.tx_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL tx_start_while_busy: got tx_busy=%b expected 0", bus.tx_busy);
      end
      bus.tx_busy = 1'b1;
      tx_cnt      = 3;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done_m   = 1'b1;
        bp_left     = bp_len;
        bp_len      = 0;
        bus.tx_busy = (bp_left > 0);
      end
    end else if (bp_left > 0) begin
      n_tests++;
      if (bus.cpu_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_cpu_hold: got %b expected 1", bus.cpu_hold);
      end
      bp_left--;
      if (bp_left == 0) bus.tx_busy = 1'b0;
    end
  end

  // Monitor: every strobe must be one-hot, non-repeating and match the head of the scoreboard queue.
  always @(negedge clk) begin
    mon_cur = {bus.tx_start, bus.mem_re, bus.dmem_we, bus.imem_we};
    if (!reset && mon_cur != 4'h0) begin
      n_tests++;
      if ($countones(mon_cur) != 1 || (mon_cur[2:0] & mon_prev[2:0]) != 3'b000) begin
        n_fail++;
        $display("FAIL strobe_excl: got %b after %b expected one-hot non-repeating", mon_cur, mon_prev);
      end
      if (mon_cur[0]) mon_act = mk(K_IMEM, bus.mem_addr, bus.mem_sel, bus.mem_wdata);
      else if (mon_cur[1]) mon_act = mk(K_DMEM, bus.mem_addr, bus.mem_sel, bus.mem_wdata);
      else if (mon_cur[2]) mon_act = mk(K_RE, bus.mem_addr, bus.mem_sel, 32'h0);
      else begin
        mon_act = mk(K_TX, 9'h0, 1'b0, {24'h0, bus.tx_data});
        tx_seen++;
      end
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got kind=%0d addr=0x%0h data=0x%0h expected none",
                 mon_act.kind, mon_act.addr, mon_act.data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL event: got kind=%0d addr=0x%0h sel=%0d data=0x%0h expected kind=%0d addr=0x%0h sel=%0d data=0x%0h",
                   mon_act.kind, mon_act.addr, mon_act.sel, mon_act.data,
                   mon_exp.kind, mon_exp.addr, mon_exp.sel, mon_exp.data);
        end
      end
    end
    mon_prev = reset ? 4'h0 : mon_cur;
  end

  initial begin
    int base;
    bus.rx_done     = 1'b1;
    bus.rx_rw_flag  = 1'b1;
    bus.rx_mem_type = 1'b1;
    bus.rx_addr     = 9'h0AB;
    bus.rx_data     = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    reset       = 1'b0;
    bus.rx_done = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_cpu_hold", {31'h0, bus.cpu_hold}, 32'h0);
    check("rst_strobes", {28'h0, bus.imem_we, bus.dmem_we, bus.mem_re, bus.tx_start}, 32'h0);
    check("rst_mem_addr", {23'h0, bus.mem_addr}, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("rst_drop_cnt", {24'h0, bus.drop_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    check("rx_done_in_reset_ignored", {31'h0, bus.busy}, 32'h0);

    // Write to data memory.
    push_write(9'h012, 1'b1, 32'hDEAD_BEEF);
    send_cmd(1'b1, 1'b1, 9'h012, 32'hDEAD_BEEF);
    wait_drain("write_dmem", 60);
    check("write_mem_addr", {23'h0, bus.mem_addr}, 32'h0000_0012);
    check("write_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);

    // Read from instruction memory at the top address.
    rd_value = 32'h1234_5678;
    push_read(9'h1FF, 1'b0, 32'h1234_5678, 4);
    send_cmd(1'b0, 1'b0, 9'h1FF, 32'h0);
    wait_drain("read_imem", 120);
    check("read_mem_addr", {23'h0, bus.mem_addr}, 32'h0000_01FF);

    // Backpressure: 10 extra busy cycles after the first byte.
    bp_len   = 10;
    rd_value = 32'hCAFE_F00D;
    push_read(9'h000, 1'b1, 32'hCAFE_F00D, 4);
    send_cmd(1'b0, 1'b1, 9'h000, 32'h0);
    wait_drain("read_backpressure", 160);

    // Three dropped commands during a read.
    rd_value = 32'hA1B2_C3D4;
    push_read(9'h055, 1'b1, 32'hA1B2_C3D4, 4);
    send_cmd(1'b0, 1'b1, 9'h055, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) drop_pulse();
    wait_drain("read_with_drops", 120);
    check("drop_cnt_3", {24'h0, bus.drop_cnt}, 32'h0000_0003);
    check("drop_keeps_addr", {23'h0, bus.mem_addr}, 32'h0000_0055);
    check("drop_keeps_wdata", bus.mem_wdata, 32'h0);

    // 300 drops saturate the counter.
    bp_len   = 700;
    rd_value = 32'h0F1E_2D3C;
    push_read(9'h100, 1'b0, 32'h0F1E_2D3C, 4);
    send_cmd(1'b0, 1'b0, 9'h100, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 300; i++) drop_pulse();
    wait_drain("read_drop_saturate", 1200);
    check("drop_cnt_sat", {24'h0, bus.drop_cnt}, 32'h0000_00FF);

    // Reset after the second byte of a read.
    rd_value = 32'h1122_3344;
    push_read(9'h0AA, 1'b0, 32'h1122_3344, 2);
    base = tx_seen;
    send_cmd(1'b0, 1'b0, 9'h0AA, 32'h0);
    for (int i = 0; i < 200; i++) begin
      if (tx_seen >= base + 2) break;
      @(negedge clk);
    end
    check("mid_reset_two_bytes", tx_seen - base, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("mid_rst_cpu_hold", {31'h0, bus.cpu_hold}, 32'h0);
    check("mid_rst_strobes", {28'h0, bus.imem_we, bus.dmem_we, bus.mem_re, bus.tx_start}, 32'h0);
    check("mid_rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("mid_rst_mem_addr", {23'h0, bus.mem_addr}, 32'h0);
    check("mid_rst_drop_cnt", {24'h0, bus.drop_cnt}, 32'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_rst_no_more_bytes", exp_q.size(), 32'd0);

    // New write to instruction memory at address zero after the abort.
    push_write(9'h000, 1'b0, 32'h0BAD_F00D);
    send_cmd(1'b1, 1'b0, 9'h000, 32'h0BAD_F00D);
    wait_drain("write_imem_after_reset", 60);
    check("write2_mem_wdata", bus.mem_wdata, 32'h0BAD_F00D);
    check("write2_mem_sel", {31'h0, bus.mem_sel}, 32'h0);

    // Stray tx_done while idle must do nothing.
    tx_done_s = 1'b1;
    @(negedge clk);
    tx_done_s = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_tx_done_busy", {31'h0, bus.busy}, 32'h0);
    check("stray_tx_done_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
